// File: rtl/cpu_boot_sequencer.sv
// cpu_boot_sequencer: loads CPU memories from a host stream, releases CPU reset, collects Out_R (watchdog under CPU_WATCHDOG_EN)
module cpu_boot_sequencer #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 4096
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic              ld_sel_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              ex_iwe_o,
  output logic              ex_dwe_o,
  output logic [ADDR_W-1:0] ex_addr_o,
  output logic [DATA_W-1:0] ex_data_o,
  output logic              cpu_rst_n_o,
  input  logic              cpu_done_i,
  input  logic [DATA_W-1:0] cpu_out_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [DATA_W-1:0] result_o,
  output logic [31:0]       run_cycles_o
);
  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;
  state_t            state_q, state_d;
  logic [31:0]       settle_q, settle_d, run_q, run_d, run_inc, run_cycles_q;
  logic              xfer, done_hit, wd_hit;
  logic              ld_ready_q, iwe_q, dwe_q, cpu_rst_n_q, busy_q, done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, result_q;
  assign xfer     = ld_valid_i & ld_ready_q & ~abort_i;
  assign done_hit = (state_q == RUN) & cpu_done_i & ~abort_i;
  assign run_inc  = &run_q ? run_q : run_q + 32'd1;
`ifdef CPU_WATCHDOG_EN
  logic timeout_q;
  assign wd_hit    = (state_q == RUN) & ~cpu_done_i & ~abort_i & (run_q == 32'(TIMEOUT_CYCLES - 1));
  assign timeout_o = timeout_q;
`else
  assign wd_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif
  assign ld_ready_o   = ld_ready_q;
  assign ex_iwe_o     = iwe_q;
  assign ex_dwe_o     = dwe_q;
  assign ex_addr_o    = addr_q;
  assign ex_data_o    = data_q;
  assign cpu_rst_n_o  = cpu_rst_n_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign result_o     = result_q;
  assign run_cycles_o = run_cycles_q;
  // next state and settle/run counters; abort overrides every state
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    run_d    = run_q;
    if (abort_i) state_d = IDLE;
    else case (state_q)
      IDLE:   state_d = start_i ? LOAD : IDLE;
      LOAD: begin
        if (xfer && ld_last_i) begin
          state_d  = SETTLE;
          settle_d = 32'd0;
        end
      end
      SETTLE: begin
        if (settle_q == 32'(SETTLE_CYCLES - 1)) begin
          state_d = RUN;
          run_d   = 32'd0;
        end else settle_d = settle_q + 32'd1;
      end
      RUN: begin
        if (cpu_done_i || wd_hit) state_d = IDLE;
        else run_d = run_inc;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, registered outputs, write strobes and result capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      run_q        <= '0;
      ld_ready_q   <= 1'b0;
      iwe_q        <= 1'b0;
      dwe_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cpu_rst_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      run_cycles_q <= '0;
`ifdef CPU_WATCHDOG_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      run_q       <= run_d;
      ld_ready_q  <= state_d == LOAD;
      cpu_rst_n_q <= state_d == RUN;
      busy_q      <= state_d != IDLE;
      iwe_q       <= xfer & ~ld_sel_i;
      dwe_q       <= xfer & ld_sel_i;
      done_q      <= done_hit;
      if (xfer) begin
        addr_q <= ld_addr_i;
        data_q <= ld_data_i;
      end
      if (done_hit) begin
        result_q     <= cpu_out_i;
        run_cycles_q <= run_inc;
      end
`ifdef CPU_WATCHDOG_EN
      timeout_q <= wd_hit;
      if (wd_hit) run_cycles_q <= 32'(TIMEOUT_CYCLES);
`endif
    end
  end
endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// tb_cpu_boot_sequencer: table-driven load vectors with a write-strobe scoreboard plus multi-cycle corner sequences
module tb_cpu_boot_sequencer;
  localparam int SETTLE = 2;
  localparam int TMO    = 16;
  logic        clk = 0, rst_i = 1, start_i = 0, abort_i = 0;
  logic        ld_valid_i = 0, ld_sel_i = 0, ld_last_i = 0, cpu_done_i = 0;
  logic [15:0] ld_addr_i = 0, ld_data_i = 0, cpu_out_i = 0;
  logic        ld_ready_o, ex_iwe_o, ex_dwe_o, cpu_rst_n_o, busy_o, done_o, timeout_o;
  logic [15:0] ex_addr_o, ex_data_o, result_o;
  logic [31:0] run_cycles_o;
  typedef struct packed {logic valid, sel, last; logic [15:0] addr, data; logic iwe, dwe;} vec_t;
  typedef struct packed {int due; logic iwe, dwe; logic [15:0] addr, data;} sb_t;
  vec_t vecs [16];
  sb_t  sb [$];
  int   cyc = 0, n_cmp = 0, n_err = 0;

  cpu_boot_sequencer #(.ADDR_W(16), .DATA_W(16), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_sel_i(ld_sel_i),
    .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i), .ld_last_i(ld_last_i),
    .ex_iwe_o(ex_iwe_o), .ex_dwe_o(ex_dwe_o), .ex_addr_o(ex_addr_o), .ex_data_o(ex_data_o),
    .cpu_rst_n_o(cpu_rst_n_o), .cpu_done_i(cpu_done_i), .cpu_out_i(cpu_out_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .result_o(result_o), .run_cycles_o(run_cycles_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {41'd0, ld_ready_o, ex_iwe_o, ex_dwe_o, ex_addr_o, ex_data_o, cpu_rst_n_o,
            busy_o, done_o, timeout_o, result_o, run_cycles_o};
  endfunction

  // every write strobe must match the oldest pending transfer, one cycle after it
  always @(negedge clk) begin
    if (ex_iwe_o || ex_dwe_o) begin
      sb_t e;
      if (sb.size() == 0) chk("we_unexpected", {ex_iwe_o, ex_dwe_o, ex_addr_o, ex_data_o}, 0);
      else begin
        e = sb.pop_front();
        chk("we_pulse", {cyc, ex_iwe_o, ex_dwe_o, ex_addr_o, ex_data_o},
            {e.due, e.iwe, e.dwe, e.addr, e.data});
      end
    end
  end

  task automatic apply(input int i);
    ld_valid_i = vecs[i].valid;
    ld_sel_i   = vecs[i].sel;
    ld_last_i  = vecs[i].last;
    ld_addr_i  = vecs[i].addr;
    ld_data_i  = vecs[i].data;
    if ((vecs[i].iwe || vecs[i].dwe) && !abort_i)
      sb.push_back('{cyc + 1, vecs[i].iwe, vecs[i].dwe, vecs[i].addr, vecs[i].data});
    @(negedge clk);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply(i);
    ld_valid_i = 0;
    ld_last_i  = 0;
  endtask

  task automatic start_session();
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    chk("load_entry", {ld_ready_o, busy_o, cpu_rst_n_o}, 3'b110);
  endtask

  task automatic wait_run();
    chk("settle_hold", cpu_rst_n_o, 0);
    repeat (SETTLE - 1) begin
      @(negedge clk);
      chk("settle_hold", cpu_rst_n_o, 0);
    end
    @(negedge clk);
    chk("run_release", {cpu_rst_n_o, busy_o}, 2'b11);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0009, 16'h1166, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h000A, 16'h1277, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h000B, 16'h1388, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h000C, 16'hFB44, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h000D, 16'hF200, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h0025, 16'h0020, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0026, 16'h0010, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 16'h000E, 16'hE100, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h0040, 16'hAAAA, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0041, 16'h1111, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h0042, 16'h2222, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 16'h0041, 16'h5555, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'h0001, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 16'h0101, 16'h0002, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 16'h0102, 16'h0003, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 16'h0200, 16'hC0DE, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    chk("reset_values", outs(), 0);
    rst_i = 0;
    @(negedge clk);
    chk("idle_after_reset", {busy_o, ld_ready_o}, 2'b00);
    // T1: full program load then run to completion
    cpu_out_i = 16'h1234;
    start_session();
    run_vecs(0, 7);
    chk("t1_ready_drop", ld_ready_o, 0);
    wait_run();
    repeat (3) @(negedge clk);
    cpu_done_i = 1;
    cpu_out_i  = 16'h0077;
    @(negedge clk);
    cpu_done_i = 0;
    chk("t1_done", {done_o, result_o, run_cycles_o, cpu_rst_n_o, busy_o}, {1'b1, 16'h0077, 32'd4, 1'b0, 1'b0});
    @(negedge clk);
    chk("t1_done_pulse_end", {done_o, result_o}, {1'b0, 16'h0077});
    // T2: gaps in ld_valid_i; cpu_done_i held high outside RUN is ignored
    cpu_done_i = 1;
    cpu_out_i  = 16'hBEEF;
    start_session();
    run_vecs(8, 11);
    chk("t2_no_early_done", {done_o, ld_ready_o, result_o}, {1'b0, 1'b0, 16'h0077});
    wait_run();
    chk("t2_run_no_done_yet", done_o, 0);
    @(negedge clk);
    cpu_done_i = 0;
    chk("t2_done_first_cycle", {done_o, result_o, run_cycles_o, cpu_rst_n_o}, {1'b1, 16'hBEEF, 32'd1, 1'b0});
    // start_i together with abort_i in IDLE stays IDLE
    start_i = 1;
    abort_i = 1;
    @(negedge clk);
    start_i = 0;
    abort_i = 0;
    chk("start_abort_idle", {busy_o, ld_ready_o}, 2'b00);
    // T4: abort after three words, with a fourth word offered in the abort cycle
    start_session();
    run_vecs(12, 14);
    ld_valid_i = 1;
    ld_addr_i  = 16'h0099;
    ld_data_i  = 16'hDEAD;
    abort_i    = 1;
    @(negedge clk);
    abort_i = 0;
    chk("t4_abort", {busy_o, ld_ready_o, cpu_rst_n_o, done_o, result_o}, {4'b0000, 16'hBEEF});
    repeat (2) @(negedge clk);
    chk("t4_stay_idle", {busy_o, ld_ready_o}, 2'b00);
    ld_valid_i = 0;
`ifdef CPU_WATCHDOG_EN
    // T3: watchdog expiry
    start_session();
    run_vecs(15, 15);
    wait_run();
    repeat (TMO - 1) @(negedge clk);
    chk("t3_before_expiry", {timeout_o, cpu_rst_n_o}, 2'b01);
    @(negedge clk);
    chk("t3_timeout", {timeout_o, done_o, run_cycles_o, cpu_rst_n_o, busy_o, result_o},
        {2'b10, 32'd16, 2'b00, 16'hBEEF});
    @(negedge clk);
    chk("t3_timeout_pulse_end", timeout_o, 0);
    // T5: done in the last watchdog cycle wins
    start_session();
    run_vecs(15, 15);
    wait_run();
    repeat (TMO - 1) @(negedge clk);
    cpu_done_i = 1;
    cpu_out_i  = 16'h1357;
    @(negedge clk);
    cpu_done_i = 0;
    chk("t5_collision", {done_o, timeout_o, run_cycles_o, result_o}, {2'b10, 32'd16, 16'h1357});
`else
    // without the watchdog RUN waits past any limit
    start_session();
    run_vecs(15, 15);
    wait_run();
    repeat (19) @(negedge clk);
    chk("nowd_still_running", {timeout_o, cpu_rst_n_o, busy_o}, 3'b011);
    cpu_done_i = 1;
    cpu_out_i  = 16'h2468;
    @(negedge clk);
    cpu_done_i = 0;
    chk("nowd_done", {done_o, timeout_o, run_cycles_o, result_o}, {2'b10, 32'd20, 16'h2468});
`endif
    // T6: synchronous reset in the middle of RUN
    start_session();
    run_vecs(15, 15);
    wait_run();
    repeat (2) @(negedge clk);
    rst_i = 1;
    @(negedge clk);
    chk("t6_reset_mid_run", outs(), 0);
    rst_i = 0;
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
